multi_delay_line: RTL and testbench
===================================

# multi_delay_line

Multi-channel, sample-count programmable delay line. Each channel delays its input stream by a run-time selectable number of valid samples, from 0 to 2^DELAY_WIDTH−1. It generalises the single-channel fixed-width delay: per-channel delay programming, a valid-qualified stream, a zero-fill guarantee after reset, and optional slewed delay changes. It sits in the feedback path between the ADC-side filter chain and the DAC-side output stage.

## Interface
- WIDTH, 16, sample width per channel (signed two's complement; passed through untouched)
- DELAY_WIDTH, 8, delay register width; buffer depth = 2^DELAY_WIDTH samples per channel
- CHANNELS, 2, number of independent channels
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- data_i  in  CHANNELS*WIDTH  packed samples; channel k at [k*WIDTH +: WIDTH]
- valid_i  in  1  sample strobe, common to all channels
- delta_i  in  CHANNELS*DELAY_WIDTH  requested delays; channel k at [k*DELAY_WIDTH +: DELAY_WIDTH]
- delta_load_i  in  CHANNELS  per-channel load strobe for delta_i
- data_o  out  CHANNELS*WIDTH  delayed samples
- valid_o  out  1  valid_i delayed by one cycle
- delta_o  out  CHANNELS*DELAY_WIDTH  delay currently applied per channel

## Operation
- Per channel: circular buffer of 2^DELAY_WIDTH × WIDTH (inferred block/distributed RAM), shared write pointer wp, per-channel target register tgt[k], applied-delay register cur[k].
- On valid_i: write data_i[k] at wp; read address = (wp − cur[k]) mod 2^DELAY_WIDTH; wp increments, wrapping 2^DELAY_WIDTH−1 → 0.
- cur[k] = 0: output is the sample presented in the same cycle (write-first bypass, not a stale RAM word).
- Fill counter fill: counts accepted samples since reset, saturates at 2^DELAY_WIDTH−1. If cur[k] > fill, output for channel k is 0. RAM contents are never cleared; this counter alone guarantees zeros after reset.
- delta_load_i[k] high: tgt[k] ← delta_i[k] on that edge. Other channels unaffected.
- delta_load_i[k] and valid_i in the same cycle: that sample uses the old cur[k]; the new value governs the next valid sample.
- No valid_i: wp, fill and data_o hold; cur[k] may still take tgt[k] (non-ramp mode).
- Arithmetic: address subtraction is modulo 2^DELAY_WIDTH with no carry out; delay values are unsigned.

## Timing
- Latency: data_o and valid_o registered; a sample at cycle t appears at t+1 with valid_o=1.
- data_o holds its value while valid_o=0.
- Reset (any cycle, including mid-stream): wp=0, fill=0, tgt=cur=0, data_o=0, valid_o=0, delta_o=0. A valid_i asserted together with rst_i is discarded.
- First valid sample after reset with delay D>0 outputs 0; the first non-zero-fill output appears on the (D+1)-th valid sample.
- delta_o reflects cur[k], updated on the same edge cur[k] changes.
- Throughput: one sample per cycle, valid_i may stay high continuously.

## Configuration
- DELAY_RAMP_EN defined: cur[k] moves toward tgt[k] by ±1 per valid sample. This limits a delay jump to a one-sample skip or repeat per step, avoiding output glitches in the feedback loop. cur[k] stops exactly at tgt[k].
- DELAY_RAMP_EN undefined: cur[k] ← tgt[k] on the cycle after the load, i.e. the new delay fully applies to the next valid sample.

## Test plan
- Reset, load delay 3 on channel 0 and 0 on channel 1, stream ramp 1,2,3,… continuously -> ch0 outputs 0,0,0,1,2,…; ch1 outputs 1,2,3,… each one cycle after input; valid_o follows valid_i by one cycle.
- Delay 255 (DELAY_WIDTH=8), stream 600 samples -> zeros for the first 255 outputs, then output n = input n−255 across wp wrap at 255→0.
- Gapped valid_i (1 on, 2 off) with delay 2 -> delay counted in samples, not cycles; data_o holds during gaps.
- Load delay 1→5 on a sample cycle with DELAY_RAMP_EN off -> that sample uses 1, next uses 5, delta_o=5. With DELAY_RAMP_EN on -> delta_o steps 2,3,4,5 on successive valid samples.
- Assert rst_i mid-stream at delay 4, then resume -> all outputs 0 the cycle after reset; first 4 post-reset outputs are 0 despite stale RAM contents.
- Load channel 1 only -> channel 0 delay and data unaffected.

Source files
------------

// File: rtl/multi_delay_line.sv
// Multi-channel, sample-count programmable delay line with zero-fill after reset.
// Define DELAY_RAMP_EN to slew each channel's applied delay by one sample per valid input.
module multi_delay_line #(
    parameter int WIDTH       = 16,
    parameter int DELAY_WIDTH = 8,
    parameter int CHANNELS    = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [CHANNELS*WIDTH-1:0]       data_i,
    input  logic                            valid_i,
    input  logic [CHANNELS*DELAY_WIDTH-1:0] delta_i,
    input  logic [CHANNELS-1:0]             delta_load_i,
    output logic [CHANNELS*WIDTH-1:0]       data_o,
    output logic                            valid_o,
    output logic [CHANNELS*DELAY_WIDTH-1:0] delta_o
);

    localparam int DEPTH = 1 << DELAY_WIDTH;
    localparam logic [DELAY_WIDTH-1:0] FILL_MAX = '1;

    function automatic logic [DELAY_WIDTH-1:0] sat_inc(input logic [DELAY_WIDTH-1:0] v);
        return (v == FILL_MAX) ? v : v + 1'b1;
    endfunction

`ifdef DELAY_RAMP_EN
    function automatic logic [DELAY_WIDTH-1:0] ramp_step(input logic [DELAY_WIDTH-1:0] c,
                                                         input logic [DELAY_WIDTH-1:0] t);
        if (c < t)
            return c + 1'b1;
        else if (c > t)
            return c - 1'b1;
        else
            return c;
    endfunction
`endif

    logic [DELAY_WIDTH-1:0] wp_p0;
    logic [DELAY_WIDTH-1:0] fill_p0;
    logic                   vld_p1;

    // p0: shared write pointer and fill counter, advanced once per accepted sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_p0   <= '0;
            fill_p0 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                wp_p0   <= wp_p0 + 1'b1;
                fill_p0 <= sat_inc(fill_p0);
            end
        end
    end

    assign valid_o = vld_p1;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [WIDTH-1:0]  mem [DEPTH];
        logic signed [WIDTH-1:0]  din_p0;
        logic signed [WIDTH-1:0]  rd_p0;
        logic signed [WIDTH-1:0]  dout_p1;
        logic [DELAY_WIDTH-1:0]   tgt;
        logic [DELAY_WIDTH-1:0]   tgt_nxt;
        logic [DELAY_WIDTH-1:0]   cur;
        logic [DELAY_WIDTH-1:0]   rd_addr;

        assign din_p0  = data_i[k*WIDTH +: WIDTH];
        assign tgt_nxt = delta_load_i[k] ? delta_i[k*DELAY_WIDTH +: DELAY_WIDTH] : tgt;
        assign rd_addr = wp_p0 - cur;

        // RAM is never cleared; the fill counter alone masks stale words after reset
        always_ff @(posedge clk_i) begin
            if (valid_i && !rst_i)
                mem[wp_p0] <= din_p0;
        end

        // p0: delay 0 bypasses the RAM so the same-cycle sample comes out, not an old word
        always_comb begin
            rd_p0 = '0;
            if (cur == '0)
                rd_p0 = din_p0;
            else if (cur > fill_p0)
                rd_p0 = '0;
            else
                rd_p0 = mem[rd_addr];
        end

        // p1: registered output; cur is read before it updates, so a load on a sample cycle
        // only affects the following sample
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                tgt     <= '0;
                cur     <= '0;
                dout_p1 <= '0;
            end else begin
                tgt <= tgt_nxt;
`ifdef DELAY_RAMP_EN
                if (valid_i)
                    cur <= ramp_step(cur, tgt_nxt);
`else
                cur <= tgt_nxt;
`endif
                if (valid_i)
                    dout_p1 <= rd_p0;
            end
        end

        assign data_o[k*WIDTH +: WIDTH]             = dout_p1;
        assign delta_o[k*DELAY_WIDTH +: DELAY_WIDTH] = cur;
    end

endmodule

// File: tb/tb_multi_delay_line.sv
// Bench for multi_delay_line (WIDTH=16, DELAY_WIDTH=8, CHANNELS=2); honours DELAY_RAMP_EN.
module tb_multi_delay_line;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic [15:0] delta_i;
    logic [1:0]  delta_load_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic [15:0] delta_o;

    multi_delay_line #(.WIDTH(16), .DELAY_WIDTH(8), .CHANNELS(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .delta_i(delta_i), .delta_load_i(delta_load_i),
        .data_o(data_o), .valid_o(valid_o), .delta_o(delta_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    typedef struct {
        bit          v;
        logic [15:0] x0, x1;
        bit          ld;
        logic [7:0]  dl0, dl1;
        bit          chk;
        logic [15:0] e0, e1;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] hist0[$];
    logic [15:0] hist1[$];
    exp_t        exp_q[$];
    int          d0, d1, t0, t1;
    logic [31:0] last_exp;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] h[$], input int d);
        int n;
        n = h.size() - 1;
        return (d <= n) ? h[n-d] : 16'h0;
    endfunction

    function automatic int step_to(input int c, input int t);
        return (c < t) ? c + 1 : (c > t) ? c - 1 : c;
    endfunction

    task automatic cycle(input bit v, input logic [15:0] x0, input logic [15:0] x1,
                         input bit ld0, input bit ld1, input logic [7:0] dl0, input logic [7:0] dl1);
        exp_t e;
        @(negedge clk_i);
        rst_i        = 1'b0;
        valid_i      = v;
        data_i       = {x1, x0};
        delta_load_i = {ld1, ld0};
        delta_i      = {dl1, dl0};
        if (v) begin
            hist0.push_back(x0);
            hist1.push_back(x1);
            e.e0 = model(hist0, d0);
            e.e1 = model(hist1, d1);
            exp_q.push_back(e);
        end
        if (ld0) t0 = int'(dl0);
        if (ld1) t1 = int'(dl1);
`ifdef DELAY_RAMP_EN
        if (v) begin
            d0 = step_to(d0, t0);
            d1 = step_to(d1, t1);
        end
`else
        d0 = t0;
        d1 = t1;
`endif
        @(posedge clk_i);
        #1;
        check("valid_o", {31'b0, valid_o}, {31'b0, v});
        if (v) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard: got empty queue expected one entry");
            end else begin
                e = exp_q.pop_front();
                check("data_ch0", {16'b0, data_o[15:0]}, {16'b0, e.e0});
                check("data_ch1", {16'b0, data_o[31:16]}, {16'b0, e.e1});
                last_exp = {e.e1, e.e0};
            end
        end else begin
            check("data_hold", data_o, last_exp);
        end
        check("delta_o", {16'b0, delta_o}, {16'b0, d1[7:0], d0[7:0]});
    endtask

    task automatic do_reset(input bit v);
        @(negedge clk_i);
        rst_i        = 1'b1;
        valid_i      = v;
        data_i       = $urandom;
        delta_load_i = 2'b11;
        delta_i      = 16'hffff;
        @(posedge clk_i);
        #1;
        check("rst_valid_o", {31'b0, valid_o}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_delta_o", {16'b0, delta_o}, 32'd0);
        hist0.delete();
        hist1.delete();
        exp_q.delete();
        d0 = 0; d1 = 0; t0 = 0; t1 = 0;
        last_exp = '0;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; delta_i = '0; delta_load_i = '0;
        d0 = 0; d1 = 0; t0 = 0; t1 = 0; last_exp = '0;

        tbl[0] = '{1'b0, 16'd0, 16'd0,   1'b1, 8'd3, 8'd0, 1'b0, 16'd0, 16'd0};
        tbl[1] = '{1'b1, 16'd1, 16'd101, 1'b0, 8'd0, 8'd0, 1'b1, 16'd0, 16'd101};
        tbl[2] = '{1'b1, 16'd2, 16'd102, 1'b0, 8'd0, 8'd0, 1'b1, 16'd0, 16'd102};
        tbl[3] = '{1'b1, 16'd3, 16'd103, 1'b0, 8'd0, 8'd0, 1'b1, 16'd0, 16'd103};
        tbl[4] = '{1'b1, 16'd4, 16'd104, 1'b0, 8'd0, 8'd0, 1'b1, 16'd1, 16'd104};
        tbl[5] = '{1'b1, 16'd5, 16'd105, 1'b0, 8'd0, 8'd0, 1'b1, 16'd2, 16'd105};
        tbl[6] = '{1'b1, 16'd6, 16'd106, 1'b0, 8'd0, 8'd0, 1'b1, 16'd3, 16'd106};
        tbl[7] = '{1'b0, 16'd77, 16'd77, 1'b0, 8'd0, 8'd0, 1'b1, 16'd3, 16'd106};
        tbl[8] = '{1'b1, 16'd7, 16'd107, 1'b0, 8'd0, 8'd0, 1'b1, 16'd4, 16'd107};

        // reset state, with a sample and loads presented during reset
        do_reset(1'b1);
        do_reset(1'b0);

        // delay 3 on ch0, 0 on ch1, ramp stream
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].x0, tbl[i].x1, tbl[i].ld, tbl[i].ld, tbl[i].dl0, tbl[i].dl1);
`ifndef DELAY_RAMP_EN
            if (tbl[i].chk) begin
                check("tbl_ch0", {16'b0, data_o[15:0]}, {16'b0, tbl[i].e0});
                check("tbl_ch1", {16'b0, data_o[31:16]}, {16'b0, tbl[i].e1});
            end
`endif
        end

        // delay 255, 600 samples across pointer wrap
        do_reset(1'b0);
        cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 8'd255, 8'd7);
        for (int n = 0; n < 600; n++)
            cycle(1'b1, 16'(n + 1), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);

        // gapped valid, delay 2
        do_reset(1'b0);
        cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 8'd2, 8'd2);
        for (int n = 0; n < 12; n++) begin
            cycle(1'b1, 16'(n + 500), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);
            cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);
            cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);
        end

        // load ch1 only; ch0 keeps delay 2
        for (int n = 0; n < 4; n++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, n == 1, 8'd0, 8'd9);
        check("ch0_untouched", {24'b0, delta_o[7:0]}, 32'd2);
        for (int n = 0; n < 12; n++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);

        // delay change 1 -> 5 on a sample cycle
        do_reset(1'b0);
        cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 8'd1, 8'd0);
        for (int n = 0; n < 10; n++)
            cycle(1'b1, 16'(n + 1000), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);
        cycle(1'b1, 16'd2000, 16'd1, 1'b1, 1'b0, 8'd5, 8'd0);
`ifdef DELAY_RAMP_EN
        check("delta_ramp", {24'b0, delta_o[7:0]}, 32'd2);
        for (int s = 3; s <= 5; s++) begin
            cycle(1'b1, 16'(2000 + s), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);
            check("delta_ramp", {24'b0, delta_o[7:0]}, 32'(s));
        end
`else
        check("delta_jump", {24'b0, delta_o[7:0]}, 32'd5);
        for (int s = 3; s <= 5; s++)
            cycle(1'b1, 16'(2000 + s), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);
`endif
        for (int n = 0; n < 8; n++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 8'd0, 8'd0);

        // mid-stream reset at delay 4, then resume over stale RAM
        cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 8'd4, 8'd4);
        for (int n = 0; n < 10; n++)
            cycle(1'b1, 16'(n + 3000), 16'(n + 4000), 1'b0, 1'b0, 8'd0, 8'd0);
        do_reset(1'b1);
        cycle(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 8'd4, 8'd4);
        for (int n = 0; n < 10; n++)
            cycle(1'b1, 16'(n + 5000), 16'(n + 6000), 1'b0, 1'b0, 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
